// File: rtl/div_pkg.sv
// Shared constants and types for the 16-by-8 restoring divider.
package div_pkg;

    localparam int unsigned NW       = 16;
    localparam int unsigned DW       = 8;
    localparam int unsigned DIV_ITER = 16;
    localparam int unsigned CW       = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] rem_o,
    output logic          qbit_o
);

    logic [DW:0] trial;
    logic [DW:0] diff;

    always_comb begin
        trial  = {rem_i, bit_i};
        diff   = trial - {1'b0, d_i};
        qbit_o = (trial >= {1'b0, d_i});
        rem_o  = qbit_o ? diff[DW-1:0] : trial[DW-1:0];
    end

endmodule

// File: rtl/div16x8.sv
// Sequential 16-by-8 unsigned restoring divider with st/done handshake.
// Optional early exit on divide-by-zero: define DIV16X8_ZERO_EXIT_EN.
module div16x8
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic [NW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [NW-1:0] q,
    output logic [DW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic [NW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [NW-1:0] quo_q, quo_d;
    logic [DW-1:0] res_q, res_d;
    logic          err_q, err_d;
    logic [DW-1:0] step_rem;
    logic          step_qbit;
    logic          zero_start;
    logic          last_iter;

`ifdef DIV16X8_ZERO_EXIT_EN
    assign zero_start = (b == '0);
`else
    assign zero_start = 1'b0;
`endif

    assign last_iter = (cnt_q == cnt_t'(DIV_ITER - 1));

    div_step u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[NW-1]),
        .d_i    (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (st) state_d = zero_start ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        quo_d = quo_q;
        res_d = res_q;
        err_d = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (st) begin
                    cnt_d = '0;
                    dvd_d = a;
                    dvs_d = b;
                    rem_d = '0;
                    if (zero_start) begin
                        quo_d = '1;
                        res_d = a[DW-1:0];
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + cnt_t'(1);
                dvd_d = {dvd_q[NW-2:0], step_qbit};
                rem_d = step_rem;
                if (last_iter) begin
                    quo_d = {dvd_q[NW-2:0], step_qbit};
                    res_d = step_rem;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign q   = quo_q;
    assign r   = res_q;
    assign err = err_q;

endmodule

// File: tb/tb_div16x8.sv
// Self-checking bench for div16x8: directed cases plus randomized operands against an arithmetic model.
module tb_div16x8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st  = 1'b0;
    logic [15:0] a   = '0;
    logic [7:0]  b   = '0;
    logic [15:0] q;
    logic [7:0]  r;
    logic        busy, done, err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] last_q = '0;
    logic [7:0]  last_r = '0;

`ifdef DIV16X8_ZERO_EXIT_EN
    localparam bit ZE = 1'b1;
`else
    localparam bit ZE = 1'b0;
`endif

    div16x8 dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [15:0] av, input logic [7:0] bv,
                         output logic [15:0] eq, output logic [7:0] er,
                         output logic ee, output int elat);
        if (bv == 0) begin
            eq = 16'hFFFF;
            er = av[7:0];
        end else begin
            eq = av / bv;
            er = 8'(av % bv);
        end
        ee   = ZE && (bv == 0);
        elat = (ZE && bv == 0) ? 0 : 16;
    endtask

    // One start pulse; optionally a second st pulse at cycle glitch_at which must be ignored.
    task automatic run_op(input logic [15:0] av, input logic [7:0] bv, input string tag,
                          input int glitch_at);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ee;
        int          elat, lat, busy_cnt, hold_bad;
        model(av, bv, eq, er, ee, elat);
        @(negedge clk);
        chk({tag, "_idle_before"}, busy, 1'b0);
        st = 1'b1; a = av; b = bv;
        @(negedge clk);
        st = 1'b0;
        lat = 0; busy_cnt = 0; hold_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (q !== last_q || r !== last_r) hold_bad++;
            if (lat == glitch_at) begin
                st = 1'b1; a = 16'd999; b = 8'd1;
            end else begin
                st = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        st = 1'b0;
        if (busy === 1'b1) busy_cnt++;
        chk({tag, "_done"},    done, 1'b1);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_q"},       q, eq);
        chk({tag, "_r"},       r, er);
        chk({tag, "_err"},     err, ee);
        chk({tag, "_busy_cycles"}, busy_cnt, elat + 1);
        chk({tag, "_hold"},    hold_bad, 0);
        last_q = eq;
        last_r = er;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin : main
        int seen, prev_t, n;
        logic [15:0] ra;
        logic [7:0]  rb;

        // Reset state
        #1;
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_op(16'd1000, 8'd7, "d1000_7", -1);
        run_op(16'hFFFF, 8'hFF, "dFFFF_FF", -1);
        run_op(16'd5, 8'd9, "d5_9", -1);
        run_op(16'h1234, 8'd0, "div0", -1);
        run_op(16'd1, 8'd1, "d1_1", -1);
        run_op(16'd255, 8'd0, "div0_b", -1);

        // Second st during RUN is ignored
        run_op(16'd300, 8'd3, "ignore_st", 5);

        // Reset mid-operation aborts without a done pulse
        @(negedge clk);
        st = 1'b1; a = 16'd50000; b = 8'd77;
        @(negedge clk);
        st = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        last_q = '0;
        last_r = '0;

        // st held high: back-to-back operations at the minimum spacing
        @(negedge clk);
        st = 1'b1; a = 16'd65000; b = 8'd200;
        seen = 0; prev_t = -1; n = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("b2b_q", q, 16'd325);
                chk("b2b_r", r, 8'd0);
                if (prev_t >= 0) chk("b2b_spacing", t - prev_t, 18);
                prev_t = t;
                seen++;
            end
        end
        chk("b2b_pulses", seen, 3);
        st = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain", busy, 1'b0);
        last_q = 16'd325;
        last_r = 8'd0;

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op(ra, rb, $sformatf("rand%0d", i), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
